// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer.
// Walks every output neuron of a layer. For each neuron it issues IN_LEN BRAM
// reads (input, weight, bias), then drains the MAC pipeline and writes the result.
// All outputs come from flops that are updated together with the state.
module fc_layer_sequencer #(
  parameter int IN_LEN    = 84,
  parameter int OUT_LEN   = 10,
  parameter int ACC_LAT   = 2,
  parameter int BIAS_BASE = 204,
  parameter int IN_AW     = 8,
  parameter int W_AW      = 10,
  parameter int B_AW      = 8,
  parameter int OUT_AW    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              in_re,
  output logic              w_re,
  output logic              b_re,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [B_AW-1:0]   b_addr,
  output logic              mac_ena,
  output logic              mac_add,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr
);

  // The drain counter must be able to hold 0..ACC_LAT.
  localparam int DW = $clog2(ACC_LAT + 2);

  localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(IN_LEN - 1);
  localparam logic [OUT_AW-1:0] O_LAST = OUT_AW'(OUT_LEN - 1);
  localparam logic [DW-1:0]     D_LAST = DW'(ACC_LAT);
  localparam logic [B_AW-1:0]   B_BASE = B_AW'(BIAS_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IN_AW-1:0]    k_q, k_d;
  logic [OUT_AW-1:0]   o_q, o_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [IN_AW-1:0]    in_addr_q, in_addr_d;
  logic [W_AW-1:0]     w_addr_q, w_addr_d;
  logic [B_AW-1:0]     b_addr_q, b_addr_d;
  logic                mac_ena_q, mac_ena_d;
  logic                mac_add_q, mac_add_d;
  logic                out_we_q, out_we_d;
  logic [OUT_AW-1:0]   out_addr_q, out_addr_d;

  // Next-state and next-output computation; outputs describe the cycle being entered.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_d        = o_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    in_addr_d  = in_addr_q;
    w_addr_d   = w_addr_q;
    b_addr_d   = b_addr_q;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;
    // Read data returns one cycle after a FETCH cycle, so the MAC strobe trails it.
    mac_ena_d  = (state_q == S_FETCH);
    mac_add_d  = !((state_q == S_FETCH) && (k_q == '0));

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      k_d       = '0;
      o_d       = '0;
      mac_ena_d = 1'b0;
      mac_add_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d   = S_FETCH;
            busy_d    = 1'b1;
            k_d       = '0;
            o_d       = '0;
            rd_en_d   = 1'b1;
            in_addr_d = '0;
            w_addr_d  = '0;
            b_addr_d  = B_BASE;
          end
        end
        S_FETCH: begin
          if (k_q == K_LAST) begin
            state_d = S_DRAIN;
            k_d     = '0;
            drain_d = '0;
          end else begin
            k_d       = k_q + IN_AW'(1);
            rd_en_d   = 1'b1;
            in_addr_d = k_q + IN_AW'(1);
            w_addr_d  = w_addr_q + W_AW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == D_LAST) begin
            state_d    = S_WRITE;
            out_we_d   = 1'b1;
            out_addr_d = o_q;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        S_WRITE: begin
          if (o_q == O_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // The weight address keeps counting, so neuron o starts at o*IN_LEN.
            state_d   = S_FETCH;
            o_d       = o_q + OUT_AW'(1);
            k_d       = '0;
            rd_en_d   = 1'b1;
            in_addr_d = '0;
            w_addr_d  = w_addr_q + W_AW'(1);
            b_addr_d  = b_addr_q + B_AW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      o_q        <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      mac_ena_q  <= 1'b0;
      mac_add_q  <= 1'b1;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      o_q        <= o_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      b_addr_q   <= b_addr_d;
      mac_ena_q  <= mac_ena_d;
      mac_add_q  <= mac_add_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_re    = rd_en_q;
  assign w_re     = rd_en_q;
  assign b_re     = rd_en_q;
  assign in_addr  = in_addr_q;
  assign w_addr   = w_addr_q;
  assign b_addr   = b_addr_q;
  assign mac_ena  = mac_ena_q;
  assign mac_add  = mac_add_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer with a small layer (4 inputs, 2 neurons).
// Expected per-cycle outputs are written out from the cycle index of a run.
module tb_fc_layer_sequencer;

  localparam int IN_LEN    = 4;
  localparam int OUT_LEN   = 2;
  localparam int ACC_LAT   = 2;
  localparam int BIAS_BASE = 204;
  localparam int NL        = IN_LEN + ACC_LAT + 2;
  localparam int NCYC      = OUT_LEN * NL + 2;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       re;
    logic       mac_ena;
    logic       mac_add;
    logic       out_we;
    logic       chk_addr;
    logic       chk_oaddr;
    logic [7:0] in_addr;
    logic [9:0] w_addr;
    logic [7:0] b_addr;
    logic [7:0] out_addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic       busy, done, in_re, w_re, b_re, mac_ena, mac_add, out_we;
  logic [7:0] in_addr;
  logic [9:0] w_addr;
  logic [7:0] b_addr;
  logic [7:0] out_addr;

  int   checks    = 0;
  int   failures  = 0;
  int   add0_cnt  = 0;
  vec_t exp_q[$];
  vec_t full_tab[NCYC];
  vec_t idle_tab[4];

  fc_layer_sequencer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ACC_LAT(ACC_LAT), .BIAS_BASE(BIAS_BASE),
    .IN_AW(8), .W_AW(10), .B_AW(8), .OUT_AW(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .busy(busy), .done(done), .in_re(in_re), .w_re(w_re), .b_re(b_re),
    .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr),
    .mac_ena(mac_ena), .mac_add(mac_add), .out_we(out_we), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // Outputs while rstn is low.
  function automatic vec_t exp_reset();
    vec_t v;
    v = '0;
    v.mac_add   = 1'b1;
    v.chk_addr  = 1'b1;
    v.chk_oaddr = 1'b1;
    return v;
  endfunction

  // Idle outputs, optionally with the held read addresses.
  function automatic vec_t exp_idle(input logic chk, input int ia, input int wa, input int ba);
    vec_t v;
    v = '0;
    v.mac_add  = 1'b1;
    v.chk_addr = chk;
    v.in_addr  = 8'(ia);
    v.w_addr   = 10'(wa);
    v.b_addr   = 8'(ba);
    return v;
  endfunction

  // Outputs at cycle c of a layer run, cycle 0 being the first FETCH cycle.
  function automatic vec_t exp_run(input int c);
    vec_t v;
    int n, t;
    v = '0;
    v.mac_add = 1'b1;
    if (c == OUT_LEN * NL) begin
      v.busy = 1'b1;
      v.done = 1'b1;
    end else if (c > OUT_LEN * NL) begin
      v = exp_idle(1'b1, IN_LEN - 1, IN_LEN * OUT_LEN - 1, BIAS_BASE + OUT_LEN - 1);
    end else begin
      n = c / NL;
      t = c % NL;
      v.busy = 1'b1;
      if (t < IN_LEN) begin
        v.re       = 1'b1;
        v.chk_addr = 1'b1;
        v.in_addr  = 8'(t);
        v.w_addr   = 10'(n * IN_LEN + t);
        v.b_addr   = 8'(BIAS_BASE + n);
      end
      v.mac_ena = (t >= 1) && (t <= IN_LEN);
      v.mac_add = (t != 1);
      if (t == NL - 1) begin
        v.out_we    = 1'b1;
        v.chk_oaddr = 1'b1;
        v.out_addr  = 8'(n);
      end
    end
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput(input string tag, input int idx);
    vec_t e;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: scoreboard empty, got nothing to compare against", tag, idx);
      return;
    end
    e = exp_q.pop_front();
    if (!mac_add) add0_cnt++;
    ok = (busy == e.busy) && (done == e.done) && (in_re == e.re) && (w_re == e.re) &&
         (b_re == e.re) && (mac_ena == e.mac_ena) && (mac_add == e.mac_add) &&
         (out_we == e.out_we);
    if (e.chk_addr)
      ok = ok && (in_addr == e.in_addr) && (w_addr == e.w_addr) && (b_addr == e.b_addr);
    if (e.chk_oaddr)
      ok = ok && (out_addr == e.out_addr);
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: got busy=%b done=%b re=%b%b%b ena=%b add=%b we=%b ia=%0d wa=%0d ba=%0d oa=%0d; required busy=%b done=%b re=%b ena=%b add=%b we=%b ia=%0d wa=%0d ba=%0d oa=%0d (addr chk %b/%b)",
               tag, idx, busy, done, in_re, w_re, b_re, mac_ena, mac_add, out_we,
               in_addr, w_addr, b_addr, out_addr,
               e.busy, e.done, e.re, e.mac_ena, e.mac_add, e.out_we,
               e.in_addr, e.w_addr, e.b_addr, e.out_addr, e.chk_addr, e.chk_oaddr);
    end
  endtask

  // Drive one record's inputs on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    start = v.start;
    abort = v.abort;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(tag, idx);
  endtask

  // Run a full layer from a single start pulse, or with start held high.
  task automatic runLayer(input string tag, input logic hold);
    vec_t v;
    for (int i = 0; i < NCYC; i++) begin
      v = full_tab[i];
      v.start = hold || (i == 0);
      applyStimulus(v, tag, i);
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < NCYC; i++) full_tab[i] = exp_run(i);
    idle_tab[0] = exp_idle(1'b0, 0, 0, 0);
    idle_tab[0].start = 1'b1;
    idle_tab[0].abort = 1'b1;
    idle_tab[1] = idle_tab[0];
    idle_tab[2] = exp_idle(1'b0, 0, 0, 0);
    idle_tab[2].abort = 1'b1;
    idle_tab[3] = exp_idle(1'b0, 0, 0, 0);

    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    exp_q.push_back(exp_reset());
    checkOutput("reset", 0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] full layer run");
    add0_cnt = 0;
    runLayer("full", 1'b0);
    checks++;
    if (add0_cnt != OUT_LEN) begin
      failures++;
      $display("[TB] FAIL mac_add_zero_count: got %0d required %0d", add0_cnt, OUT_LEN);
    end

    $display("[TB] start with abort in IDLE");
    for (int i = 0; i < 4; i++) applyStimulus(idle_tab[i], "idle_abort", i);

    $display("[TB] start held high");
    runLayer("held", 1'b1);
    v = full_tab[0];
    v.start = 1'b1;
    applyStimulus(v, "held_rerun", 0);
    for (int i = 1; i < NCYC; i++) applyStimulus(full_tab[i], "held_rerun", i);

    $display("[TB] abort in neuron 1");
    for (int i = 0; i <= NL + 1; i++) begin
      v = full_tab[i];
      v.start = (i == 0);
      applyStimulus(v, "pre_abort", i);
    end
    v = exp_idle(1'b1, 1, IN_LEN + 1, BIAS_BASE + 1);
    v.abort = 1'b1;
    applyStimulus(v, "abort", 0);
    v.abort = 1'b0;
    for (int i = 1; i < 8; i++) applyStimulus(v, "post_abort", i);
    for (int i = 0; i < IN_LEN; i++) begin
      v = full_tab[i];
      v.start = (i == 0);
      applyStimulus(v, "restart", i);
    end
    v = exp_idle(1'b1, IN_LEN - 1, IN_LEN - 1, BIAS_BASE);
    v.abort = 1'b1;
    applyStimulus(v, "abort_fetch", 0);

    $display("[TB] reset during DRAIN");
    for (int i = 0; i <= IN_LEN + 1; i++) begin
      v = full_tab[i];
      v.start = (i == 0);
      applyStimulus(v, "pre_reset", i);
    end
    #2;
    rstn = 1'b0;
    #1;
    exp_q.push_back(exp_reset());
    checkOutput("reset_drain", 0);
    rstn = 1'b1;
    runLayer("after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
